// File: rtl/prog_loader.sv
// Serial in-circuit programming slave: decodes the PGC/PGD two-wire protocol into
// program-memory writes, readback frames and bulk erase, holding the CPU while active.
module prog_loader #(
  parameter int PIC_INSTR_WIDTH        = 12,
  parameter int PIC_INSTR_MEM_DEPTH    = 256,
  parameter int L2_PIC_INSTR_MEM_DEPTH = 8,
  parameter logic [PIC_INSTR_WIDTH-1:0] ERASE_VALUE = 12'hFFF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              prog_en,
  input  logic                              pgc,
  input  logic                              pgd_in,
  output logic                              pgd_out,
  output logic                              pgd_oe,
  output logic [L2_PIC_INSTR_MEM_DEPTH-1:0] mem_addr,
  output logic [PIC_INSTR_WIDTH-1:0]        mem_wdata,
  output logic                              mem_we,
  input  logic [PIC_INSTR_WIDTH-1:0]        mem_rdata,
  output logic                              cpu_hold,
  output logic                              busy
);

  localparam int AW      = L2_PIC_INSTR_MEM_DEPTH;
  localparam int FRAME_W = PIC_INSTR_WIDTH + 4;

  localparam logic [5:0] CMD_LOAD  = 6'h02;
  localparam logic [5:0] CMD_READ  = 6'h04;
  localparam logic [5:0] CMD_INCR  = 6'h06;
  localparam logic [5:0] CMD_PROG  = 6'h08;
  localparam logic [5:0] CMD_ERASE = 6'h09;

  localparam logic [4:0]    CMD_LAST_BIT   = 5'd5;
  localparam logic [4:0]    FRAME_LAST_BIT = 5'(FRAME_W - 1);
  localparam logic [4:0]    BIT_ONE        = 5'd1;
  localparam logic [AW-1:0] ADDR_LAST      = AW'(PIC_INSTR_MEM_DEPTH - 1);
  localparam logic [AW-1:0] ADDR_ONE       = AW'(1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    LOAD,
    RD_FETCH,
    RD_SHIFT,
    ERASE
  } state_t;

  // Two-flop synchronizers for the asynchronous programmer pins: bit 0 = pgc, bit 1 = pgd.
  logic [1:0] pin_raw;
  logic [1:0] pin_sync;
  assign pin_raw = {pgd_in, pgc};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    logic s1_reg;
    logic s2_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_reg <= 1'b0;
        s2_reg <= 1'b0;
      end else begin
        s1_reg <= pin_raw[gi];
        s2_reg <= s1_reg;
      end
    end
    assign pin_sync[gi] = s2_reg;
  end

  logic pgc_prev_reg;
  logic pgc_fall;
  logic pgc_rise;
  assign pgc_fall = pgc_prev_reg & ~pin_sync[0];
  assign pgc_rise = ~pgc_prev_reg & pin_sync[0];

  state_t                     state_reg, state_next;
  logic [AW-1:0]              addr_reg, addr_next;
  logic [AW-1:0]              erase_cnt_reg, erase_cnt_next;
  logic [PIC_INSTR_WIDTH-1:0] latch_reg, latch_next;
  logic [FRAME_W-1:0]         shift_reg, shift_next;
  logic [4:0]                 bit_cnt_reg, bit_cnt_next;
  logic                       fetch_ph_reg, fetch_ph_next;
  logic                       prog_we_reg, prog_we_next;
  logic                       cpu_hold_reg;

  logic [FRAME_W-1:0] shift_in;
  logic [5:0]         cmd_code;
  assign shift_in = {pin_sync[1], shift_reg[FRAME_W-1:1]};
  assign cmd_code = shift_in[FRAME_W-1 -: 6];

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    erase_cnt_next = erase_cnt_reg;
    latch_next     = latch_reg;
    shift_next     = shift_reg;
    bit_cnt_next   = bit_cnt_reg;
    fetch_ph_next  = fetch_ph_reg;
    prog_we_next   = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (prog_en) begin
          state_next   = CMD;
          addr_next    = '0;
          bit_cnt_next = '0;
          shift_next   = '0;
        end
      end
      CMD: begin
        if (pgc_fall) begin
          shift_next   = shift_in;
          bit_cnt_next = bit_cnt_reg + BIT_ONE;
          if (bit_cnt_reg == CMD_LAST_BIT) begin
            bit_cnt_next = '0;
            shift_next   = '0;
            case (cmd_code)
              CMD_LOAD: state_next = LOAD;
              CMD_READ: begin
                state_next    = RD_FETCH;
                fetch_ph_next = 1'b0;
              end
              CMD_INCR: addr_next = (addr_reg == ADDR_LAST) ? '0 : addr_reg + ADDR_ONE;
              CMD_PROG: prog_we_next = 1'b1;
              CMD_ERASE: begin
                state_next     = ERASE;
                erase_cnt_next = '0;
              end
              default: ;
            endcase
          end
        end
      end
      LOAD: begin
        if (pgc_fall) begin
          shift_next   = shift_in;
          bit_cnt_next = bit_cnt_reg + BIT_ONE;
          if (bit_cnt_reg == FRAME_LAST_BIT) begin
            // Frame bit 0 is the start bit; the data word sits in bits 1..W.
            latch_next   = shift_in[PIC_INSTR_WIDTH:1];
            state_next   = CMD;
            bit_cnt_next = '0;
            shift_next   = '0;
          end
        end
      end
      RD_FETCH: begin
        // Phase 0 presents the address; phase 1 captures the registered read data.
        fetch_ph_next = 1'b1;
        if (fetch_ph_reg) begin
          shift_next   = {3'b000, mem_rdata, 1'b0};
          bit_cnt_next = '0;
          state_next   = RD_SHIFT;
        end
      end
      RD_SHIFT: begin
        // Bit 0 is already on the pin, so the first rising edge must not advance.
        if (pgc_rise && bit_cnt_reg != '0) begin
          shift_next = {1'b0, shift_reg[FRAME_W-1:1]};
        end
        if (pgc_fall) begin
          bit_cnt_next = bit_cnt_reg + BIT_ONE;
          if (bit_cnt_reg == FRAME_LAST_BIT) begin
            state_next   = CMD;
            bit_cnt_next = '0;
            shift_next   = '0;
          end
        end
      end
      ERASE: begin
        if (erase_cnt_reg == ADDR_LAST) begin
          state_next   = CMD;
          bit_cnt_next = '0;
          shift_next   = '0;
        end else begin
          erase_cnt_next = erase_cnt_reg + ADDR_ONE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Losing the programming request aborts whatever frame or erase is in flight.
    if (!prog_en && state_reg != IDLE) begin
      state_next   = IDLE;
      prog_we_next = 1'b0;
      latch_next   = latch_reg;
      addr_next    = addr_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      erase_cnt_reg <= '0;
      latch_reg     <= '0;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      fetch_ph_reg  <= 1'b0;
      prog_we_reg   <= 1'b0;
      cpu_hold_reg  <= 1'b0;
      pgc_prev_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      erase_cnt_reg <= erase_cnt_next;
      latch_reg     <= latch_next;
      shift_reg     <= shift_next;
      bit_cnt_reg   <= bit_cnt_next;
      fetch_ph_reg  <= fetch_ph_next;
      prog_we_reg   <= prog_we_next;
      cpu_hold_reg  <= (state_reg != IDLE);
      pgc_prev_reg  <= pin_sync[0];
    end
  end

  assign busy      = (state_reg == ERASE);
  assign mem_we    = prog_we_reg | busy;
  assign mem_addr  = busy ? erase_cnt_reg : addr_reg;
  assign mem_wdata = busy ? ERASE_VALUE : latch_reg;
  assign pgd_oe    = (state_reg == RD_SHIFT);
  assign pgd_out   = pgd_oe & shift_reg[0];
  assign cpu_hold  = cpu_hold_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: bit-banged PGC/PGD host, behavioural program memory
// and a write scoreboard checked whenever the loader strobes mem_we.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_en;
  logic        pgc;
  logic        pgd_in;
  logic        pgd_out;
  logic        pgd_oe;
  logic [7:0]  mem_addr;
  logic [11:0] mem_wdata;
  logic        mem_we;
  logic [11:0] mem_rdata;
  logic        cpu_hold;
  logic        busy;

  prog_loader dut (
    .clk       (clk),
    .rst       (rst),
    .prog_en   (prog_en),
    .pgc       (pgc),
    .pgd_in    (pgd_in),
    .pgd_out   (pgd_out),
    .pgd_oe    (pgd_oe),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  logic [11:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0]  a;
    logic [11:0] d;
  } wr_t;
  wr_t wq[$];
  wr_t mon_e;

  logic [7:0]  addr_m;
  logic [11:0] latch_m;

  // Every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      checks++;
      assert (wq.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write observed addr=%0h data=%0h expected no write", mem_addr, mem_wdata);
      end
      if (wq.size() != 0) begin
        mon_e = wq.pop_front();
        checks++;
        assert ({mem_addr, mem_wdata} === {mon_e.a, mon_e.d}) else begin
          errors++;
          $error("FAIL write observed addr=%0h data=%0h expected addr=%0h data=%0h",
                 mem_addr, mem_wdata, mon_e.a, mon_e.d);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    pgd_in = b;
    pgc = 1'b1;
    wait_clk(6);
    pgc = 1'b0;
    wait_clk(6);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[i]);
  endtask

  task automatic send_cmd(input logic [5:0] c);
    send_bits({10'b0, c}, 6);
  endtask

  task automatic load_word(input logic [11:0] d);
    send_cmd(6'h02);
    send_bits({3'b000, d, 1'b0}, 16);
    latch_m = d;
  endtask

  task automatic prog_word(input string tag);
    wq.push_back(wr_t'({addr_m, latch_m}));
    send_cmd(6'h08);
    wait_clk(2);
    check(tag, wq.size(), 0);
  endtask

  task automatic incr_addr();
    send_cmd(6'h06);
    addr_m = addr_m + 8'd1;
  endtask

  task automatic read_word(output logic [15:0] w, output logic oe_ok);
    send_cmd(6'h04);
    oe_ok = 1'b1;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      pgd_in = 1'b0;
      pgc = 1'b1;
      wait_clk(6);
      w[i] = pgd_out;
      oe_ok = oe_ok & pgd_oe;
      pgc = 1'b0;
      wait_clk(6);
    end
  endtask

  task automatic reenter();
    prog_en = 1'b0;
    wait_clk(3);
    prog_en = 1'b1;
    wait_clk(3);
    addr_m = 8'd0;
  endtask

  // Sends BULK_ERASE and returns on the first cycle busy is seen (erase word 0).
  task automatic start_erase(input string tag);
    int n;
    send_bits(16'h0009, 5);
    pgd_in = 1'b0;
    pgc = 1'b1;
    wait_clk(6);
    pgc = 1'b0;
    n = 0;
    while (!busy && n < 20) begin
      wait_clk(1);
      n++;
    end
    check(tag, busy, 1);
  endtask

  initial begin
    logic [15:0] w;
    logic        ok;
    int          busy_cnt;

    rst = 1'b1;
    prog_en = 1'b1;
    pgc = 1'b0;
    pgd_in = 1'b0;
    addr_m = '0;
    latch_m = '0;

    // Reset holds every output low even with prog_en high and pgc toggling.
    wait_clk(1);
    for (int i = 0; i < 6; i++) begin
      pgc = ~pgc;
      wait_clk(4);
      check("reset_outputs", {pgd_out, pgd_oe, mem_we, cpu_hold, busy, mem_addr, mem_wdata}, 0);
    end
    rst = 1'b0;
    wait_clk(2);
    check("cpu_hold_after_reset", cpu_hold, 1);
    check("addr_after_reset", mem_addr, 0);

    // Load and program two words.
    load_word(12'hCAA);
    prog_word("prog_addr0_drain");
    incr_addr();
    load_word(12'h030);
    prog_word("prog_addr1_drain");
    check("addr_idle_view", mem_addr, 1);

    // Re-enter mode and read word 0 back.
    reenter();
    read_word(w, ok);
    check("readback_addr0", w, {3'b000, 12'hCAA, 1'b0});
    check("readback_oe_held", ok, 1);
    check("readback_oe_release", pgd_oe, 0);

    // 256 increments wrap the address counter back to 0.
    for (int i = 0; i < 256; i++) incr_addr();
    check("addr_wrap", mem_addr, 0);
    prog_word("prog_after_wrap_drain");

    // Full bulk erase with pgc toggling while busy.
    for (int i = 0; i < 256; i++) wq.push_back(wr_t'({8'(i), 12'hFFF}));
    start_erase("erase_start");
    busy_cnt = 0;
    pgd_in = 1'b1;
    for (int j = 0; j < 600; j++) begin
      if (!busy) break;
      busy_cnt++;
      if (j >= 8 && j <= 192 && (j % 8) == 0) pgc = ~pgc;
      wait_clk(1);
    end
    check("busy_length", busy_cnt, 256);
    check("erase_drain", wq.size(), 0);
    check("addr_kept_after_erase", mem_addr, 0);
    for (int i = 0; i < 5; i++) incr_addr();
    read_word(w, ok);
    check("readback_addr5_erased", w, {3'b000, 12'hFFF, 1'b0});
    check("readback5_oe_held", ok, 1);

    // Drop prog_en partway through a LOAD frame.
    send_cmd(6'h02);
    send_bits({3'b000, 12'h555, 1'b0}, 8);
    prog_en = 1'b0;
    wait_clk(1);
    check("abort_load_outputs", {pgd_oe, busy, mem_we}, 0);
    wait_clk(2);
    check("abort_load_cpu_hold", cpu_hold, 0);
    prog_en = 1'b1;
    wait_clk(3);
    addr_m = 8'd0;
    prog_word("latch_kept_drain");

    // Drop prog_en at erase word 100.
    for (int i = 0; i <= 100; i++) wq.push_back(wr_t'({8'(i), 12'hFFF}));
    start_erase("erase2_start");
    wait_clk(100);
    check("erase_word100_addr", mem_addr, 100);
    prog_en = 1'b0;
    wait_clk(1);
    check("abort_erase_outputs", {busy, mem_we, pgd_oe}, 0);
    wait_clk(5);
    check("abort_erase_drain", wq.size(), 0);
    check("abort_erase_cpu_hold", cpu_hold, 0);

    // Unknown command is ignored; the next command decodes cleanly.
    prog_en = 1'b1;
    wait_clk(3);
    addr_m = 8'd0;
    send_cmd(6'h3F);
    check("unknown_cmd_no_busy", {busy, pgd_oe}, 0);
    prog_word("after_unknown_drain");
    read_word(w, ok);
    check("readback_addr0_final", w, {3'b000, 12'h030, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
